// File: rtl/uart_link_pkg.sv
// uart_link_pkg: shared arbiter state type and UART link-layer constants.
// No ports.
package uart_link_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    localparam int UART_DATA_WIDTH    = 8;
    localparam int UART_TX_FIFO_DEPTH = 10;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector.
// Ports:
//   req_i  - request vector
//   ptr_i  - index of the last served requester; the scan starts at ptr_i+1
//   pick_o - one-hot winner (0 when no request)
//   idx_o  - winner index (0 when no request)
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  pick_o,
    output logic [IW-1:0] idx_o
);

    // The scan runs from the farthest candidate to the nearest, so the
    // requester closest after the pointer overwrites the others.
    always_comb begin
        idx_o = '0;
        for (int k = N; k >= 1; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) idx_o = IW'((int'(ptr_i) + k) % N);
        end
        pick_o = (|req_i) ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locking arbiter that shares one UART
// TX FIFO between NUM_REQ byte-stream requesters, with credit-based occupancy
// tracking so the FIFO is never pushed while full.
// Ports:
//   clk, reset_n (async active-low), ena (global enable; freezes all state)
//   req_data/req_valid/req_last - packed per-requester byte streams
//   req_ready                   - per-requester accept (combinational)
//   fifo_data/fifo_data_valid   - registered push to the TX FIFO write port
//   fifo_pop                    - FIFO output pulse; returns one credit
//   grant, occupancy, busy      - status
//   timeout_o                   - only with UART_TX_ARB_TIMEOUT_EN: one-cycle
//                                 pulse when a stalled owner loses its grant
// Optional macro: UART_TX_ARB_TIMEOUT_EN (stall timeout release).
module uart_tx_arbiter
    import uart_link_pkg::*;
#(
    parameter int DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int NUM_REQ        = 4,
    parameter int FIFO_DEPTH     = UART_TX_FIFO_DEPTH,
    parameter int MAX_BURST      = 16,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int OW = $clog2(FIFO_DEPTH + 1),
    localparam int IW = $clog2(NUM_REQ),
    localparam int BW = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ena,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic                          fifo_data_valid,
    input  logic                          fifo_pop,
    output logic [NUM_REQ-1:0]            grant,
    output logic [OW-1:0]                 occupancy,
    output logic                          busy
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    output logic                          timeout_o
`endif
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: parameter out of range");
    end

    arb_state_t            state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d, pick;
    logic [IW-1:0]         gidx_q, gidx_d, ptr_q, ptr_d, pick_idx;
    logic [BW-1:0]         burst_q, burst_d;
    logic [OW-1:0]         occ_q, occ_d;
    logic [DATA_WIDTH-1:0] fdata_q, fdata_d;
    logic                  fvalid_q, fvalid_d, hs, pop_eff, release_msg;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
    logic [SW-1:0]         stall_q, stall_d;
    logic                  timeout_q, timeout_d;
`endif

    rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
        .req_i  (req_valid),
        .ptr_i  (ptr_q),
        .pick_o (pick),
        .idx_o  (pick_idx)
    );

    assign hs      = |(req_valid & req_ready);
    // A pop seen with no credits outstanding has nothing to return.
    assign pop_eff = fifo_pop && (occ_q != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= IW'(NUM_REQ - 1);
            burst_q   <= '0;
            occ_q     <= '0;
            fdata_q   <= '0;
            fvalid_q  <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            stall_q   <= '0;
            timeout_q <= 1'b0;
`endif
        end else if (ena) begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            burst_q   <= burst_d;
            occ_q     <= occ_d;
            fdata_q   <= fdata_d;
            fvalid_q  <= fvalid_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        burst_d     = burst_q;
        fvalid_d    = hs;
        fdata_d     = hs ? req_data[gidx_q*DATA_WIDTH +: DATA_WIDTH] : fdata_q;
        occ_d       = (hs && !pop_eff) ? occ_q + 1'b1 : (!hs && pop_eff) ? occ_q - 1'b1 : occ_q;
        release_msg = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        timeout_d   = 1'b0;
        stall_d     = (state_q != LOCKED || hs) ? '0 : !req_valid[gidx_q] ? stall_q + 1'b1 : stall_q;
`endif
        if (state_q == IDLE) begin
            if (|req_valid) begin
                state_d = LOCKED;
                grant_d = pick;
                gidx_d  = pick_idx;
                burst_d = '0;
            end
        end else begin
            burst_d     = hs ? burst_q + 1'b1 : burst_q;
            release_msg = hs && (req_last[gidx_q] || burst_d == BW'(MAX_BURST));
`ifdef UART_TX_ARB_TIMEOUT_EN
            if (stall_d == SW'(TIMEOUT_CYCLES)) begin
                release_msg = 1'b1;
                timeout_d   = 1'b1;
            end
`endif
            if (release_msg) begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = gidx_q;
            end
        end
    end

    // Grant stays with a full FIFO; only the ready is withheld.
    always_comb begin
        req_ready = (ena && state_q == LOCKED && occ_q < OW'(FIFO_DEPTH)) ? grant_q : '0;
    end

    assign fifo_data       = fdata_q;
    assign fifo_data_valid = fvalid_q;
    assign grant           = grant_q;
    assign occupancy       = occ_q;
    assign busy            = state_q != IDLE;
`ifdef UART_TX_ARB_TIMEOUT_EN
    assign timeout_o       = timeout_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0, reset_n = 1'b1, ena = 1'b1, fifo_pop = 1'b0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0] req_valid = '0, req_last = '0;
    logic [N-1:0] req_ready, grant;
    logic [7:0]   fifo_data;
    logic         fifo_data_valid, busy;
    logic [3:0]   occupancy;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic         timeout_o;
`endif

    int         checks = 0, errors = 0, cyc = 0, occ_m = 0;
    logic [7:0] sb[$];
    int         src_base[N], src_len[N], src_pos[N], first_hs[N], last_hs[N];
    logic       src_last[N];
    logic       exp_fv = 1'b0;
    logic [7:0] exp_fd = '0;

    uart_tx_arbiter dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ena             (ena),
        .req_data        (req_data),
        .req_valid       (req_valid),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .fifo_data       (fifo_data),
        .fifo_data_valid (fifo_data_valid),
        .fifo_pop        (fifo_pop),
        .grant           (grant),
        .occupancy       (occupancy),
        .busy            (busy)
`ifdef UART_TX_ARB_TIMEOUT_EN
        ,
        .timeout_o       (timeout_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every ena-cycle presenting a push consumes one expected byte.
    always @(negedge clk) begin
        if (reset_n && ena && fifo_data_valid) begin
            chk("sb_pending", sb.size() != 0, 1);
            if (sb.size() != 0) chk("sb_data", fifo_data, sb.pop_front());
        end
    end

    function automatic void drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = src_pos[i] < src_len[i];
            req_data[i*8 +: 8] = 8'(src_base[i] + src_pos[i]);
            req_last[i]        = src_last[i] && (src_pos[i] == src_len[i] - 1);
        end
    endfunction

    function automatic void msg(int i, int base, int len, logic last);
        src_base[i] = base;
        src_len[i]  = len;
        src_pos[i]  = 0;
        src_last[i] = last;
        drive();
    endfunction

    function automatic logic all_done();
        for (int i = 0; i < N; i++) if (src_pos[i] < src_len[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step();
        logic [N-1:0] hs;
        logic         en, pop;
        @(negedge clk);
        hs  = req_valid & req_ready;
        en  = ena;
        pop = fifo_pop;
        @(posedge clk);
        #1;
        cyc++;
        if (en) begin
            exp_fv = hs != 0;
            occ_m  = occ_m - ((pop && occ_m > 0) ? 1 : 0) + ((hs != 0) ? 1 : 0);
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    exp_fd = 8'(src_base[i] + src_pos[i]);
                    if (src_pos[i] == 0) first_hs[i] = cyc;
                    last_hs[i] = cyc;
                    src_pos[i]++;
                end
            end
        end
        chk("fifo_data_valid", fifo_data_valid, exp_fv);
        if (exp_fv) chk("fifo_data", fifo_data, exp_fd);
        chk("occupancy", occupancy, occ_m);
        drive();
        if (occ_m >= 10 || !ena) chk("ready_blocked", req_ready, 0);
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic run_done(int bound);
        int n = 0;
        while (!all_done() && n < bound) begin
            step();
            n++;
        end
        chk("msg_done_in_time", all_done(), 1);
    endtask

    task automatic run_until(int i, int pos, int bound);
        int n = 0;
        while (src_pos[i] < pos && n < bound) begin
            step();
            n++;
        end
        chk("reach_pos", src_pos[i], pos);
    endtask

    task automatic drain();
        fifo_pop = 1'b1;
        idle(12);
        fifo_pop = 1'b0;
        chk("drained", occupancy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            src_base[i] = 0; src_len[i] = 0; src_pos[i] = 0;
            src_last[i] = 1'b0; first_hs[i] = 0; last_hs[i] = 0;
        end
        #1 reset_n = 1'b0;
        #11;
        chk("rst_grant", grant, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_fdata", fifo_data, 0);
        chk("rst_fvalid", fifo_data_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Single requester, three bytes, no pops.
        msg(0, 'h41, 3, 1'b1);
        sb.push_back(8'h41); sb.push_back(8'h42); sb.push_back(8'h43);
        run_done(20);
        idle(2);
        chk("t1_occ", occupancy, 3);
        chk("t1_grant", grant, 0);
        chk("t1_busy", busy, 0);

        // Two competing requesters: 1 then 2 with one idle cycle between.
        drain();
        msg(1, 'h11, 2, 1'b1);
        msg(2, 'h21, 2, 1'b1);
        sb.push_back(8'h11); sb.push_back(8'h12); sb.push_back(8'h21); sb.push_back(8'h22);
        run_done(20);
        chk("t2_gap", first_hs[2] - last_hs[1], 2);
        msg(1, 'h15, 1, 1'b1);
        msg(3, 'h31, 1, 1'b1);
        sb.push_back(8'h31); sb.push_back(8'h15);
        run_done(20);
        chk("t2_rr_next", first_hs[3] < first_hs[1], 1);

        // FIFO full: ready drops after 10 bytes, one pop releases one byte.
        drain();
        msg(0, 'h60, 12, 1'b1);
        for (int k = 0; k < 12; k++) sb.push_back(8'('h60 + k));
        run_until(0, 10, 40);
        idle(4);
        chk("t3_stall_pos", src_pos[0], 10);
        chk("t3_ready_full", req_ready, 0);
        chk("t3_grant_kept", grant, 4'b0001);
        chk("t3_occ_full", occupancy, 10);
        fifo_pop = 1'b1;
        step();
        fifo_pop = 1'b0;
        idle(4);
        chk("t3_one_more", src_pos[0], 11);
        fifo_pop = 1'b1;
        run_done(30);
        idle(2);
        fifo_pop = 1'b0;

        // Burst limit: 20 unterminated bytes, released after 16 for requester 3.
        drain();
        fifo_pop = 1'b1;
        msg(2, 'h80, 20, 1'b0);
        msg(3, 'hA0, 1, 1'b1);
        for (int k = 0; k < 16; k++) sb.push_back(8'('h80 + k));
        sb.push_back(8'hA0);
        for (int k = 16; k < 20; k++) sb.push_back(8'('h80 + k));
        run_done(60);
        idle(4);
        chk("t4_hold_grant", grant, 4'b0100);
        chk("t4_hold_busy", busy, 1);
        src_len[2]  = 21;
        src_last[2] = 1'b1;
        drive();
        sb.push_back(8'h94);
        run_done(10);
        idle(2);
        chk("t4_released", grant, 0);
        fifo_pop = 1'b0;

        // ena low for 5 cycles right after a handshake.
        drain();
        msg(1, 'h51, 2, 1'b1);
        sb.push_back(8'h51); sb.push_back(8'h52);
        run_until(1, 1, 10);
        ena = 1'b0;
        idle(5);
        chk("t5_hold_valid", fifo_data_valid, 1);
        chk("t5_hold_occ", occupancy, 1);
        ena = 1'b1;
        run_done(10);
        idle(2);
        chk("t5_occ", occupancy, 2);

        // Asynchronous reset mid-message.
        drain();
        msg(0, 'h70, 5, 1'b1);
        sb.push_back(8'h70); sb.push_back(8'h71);
        run_until(0, 2, 10);
        chk("t6_occ_before", occupancy, 2);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_grant", grant, 0);
        chk("t6_ready", req_ready, 0);
        chk("t6_fdata", fifo_data, 0);
        chk("t6_fvalid", fifo_data_valid, 0);
        chk("t6_occ", occupancy, 0);
        chk("t6_busy", busy, 0);
        src_len[0] = 0;
        drive();
        exp_fv = 1'b0;
        occ_m  = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        msg(0, 'hB0, 1, 1'b1);
        msg(2, 'hC0, 1, 1'b1);
        sb.push_back(8'hB0); sb.push_back(8'hC0);
        run_done(10);
        chk("t6_ptr_reset", first_hs[0] < first_hs[2], 1);

`ifdef UART_TX_ARB_TIMEOUT_EN
        begin
            int pulses = 0;
            msg(1, 'hE0, 1, 1'b0);
            sb.push_back(8'hE0);
            run_done(10);
            repeat (300) begin
                step();
                pulses += int'(timeout_o);
            end
            chk("t7_pulses", pulses, 1);
            chk("t7_grant", grant, 0);
        end
`endif

        idle(3);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
